// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the debug-link UART transmitter and
// receiver so both ends agree on bit timing and frame length.
package uart_pkg;

  // Last value of the per-bit clock counter; one bit lasts BAUD_END+1 clocks.
  // 56 keeps simulation short; use calc_baud_end() for a real board.
  localparam int BAUD_END = 56;

  // Counter value at which a bit is sampled (its midpoint).
  localparam int BAUD_MID = BAUD_END / 2;

  // Index of the stop bit within a frame (start = 0, data = 1..8, stop = 9).
  localparam int BIT_END = 9;

  // Receiver states: waiting for a start edge, validating the start bit,
  // collecting the eight data bits, checking the stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Derives BAUD_END from the system clock and line rate for a board build.
  function automatic int calc_baud_end(input int clk_hz, input int baud_rate);
    return (clk_hz / baud_rate) - 1;
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: brings the asynchronous serial line into the clock domain
// with two flops and flags a high-to-low transition of the synchronised line.
// All flops reset to 1, the idle level of the line, so leaving reset with the
// line already low never looks like a start edge.
module uart_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s2,
  output logic fall
);

  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_d;

  // Two-stage metastability filter plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign rx_s2 = r_rx_s2;
  assign fall  = r_rx_d & ~r_rx_s2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel receiver for the SDRAM test-harness debug link.
// Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
// Each bit is sampled at its midpoint; a good frame updates rx_data with a
// one-cycle rx_valid pulse, a low stop bit gives a one-cycle rx_err pulse.
// The receiver returns to IDLE at mid-stop so the next start edge has half a
// bit of margin, which lets back-to-back transmitter frames through.
module uart_rx #(
  parameter int BAUD_END = uart_pkg::BAUD_END
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int CW = $clog2(BAUD_END + 1);
  localparam logic [CW-1:0] CNT_END = CW'(BAUD_END);
  localparam logic [CW-1:0] CNT_MID = CW'(BAUD_END / 2);

  logic            w_rx_s2;
  logic            w_fall;

  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [CW-1:0]   r_baud_cnt;
  logic [CW-1:0]   w_baud_cnt_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shreg;
  logic [7:0]      w_shreg_nxt;
  logic [7:0]      r_rx_data;
  logic [7:0]      w_rx_data_nxt;
  logic            r_rx_valid;
  logic            w_rx_valid_nxt;
  logic            r_rx_err;
  logic            w_rx_err_nxt;
  logic            w_cnt_mid;
  logic            w_cnt_end;

  uart_sync_edge u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .rx    (rx),
    .rx_s2 (w_rx_s2),
    .fall  (w_fall)
  );

  assign w_cnt_mid = (r_baud_cnt == CNT_MID);
  assign w_cnt_end = (r_baud_cnt == CNT_END);

  // Next-state and datapath decisions; everything holds unless a state acts.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = w_cnt_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_idx_nxt  = r_bit_idx;
    w_shreg_nxt    = r_shreg;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_rx_err_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        w_baud_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = START;
        end
      end

      START: begin
        if (w_cnt_mid && w_rx_s2) begin
          w_state_nxt    = IDLE;
          w_baud_cnt_nxt = '0;
        end else if (w_cnt_end) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end

      DATA: begin
        if (w_cnt_mid) begin
          w_shreg_nxt = {w_rx_s2, r_shreg[7:1]};
        end
        if (w_cnt_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (w_cnt_mid) begin
          w_state_nxt    = IDLE;
          w_baud_cnt_nxt = '0;
          if (w_rx_s2) begin
            w_rx_data_nxt  = r_shreg;
            w_rx_valid_nxt = 1'b1;
          end else begin
            w_rx_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt    = IDLE;
        w_baud_cnt_nxt = '0;
      end
    endcase
  end

  // State, counters and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shreg    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_err   <= w_rx_err_nxt;
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;
  assign rx_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and compares its outputs with
// a frame-level model that predicts when each valid/err pulse must appear.
module tb_uart_rx;

  localparam int BIT_CLKS   = 57;
  localparam int MID        = 28;
  localparam int PULSE_OFFS = 2 + 9 * BIT_CLKS + MID + 1;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         gap;
    logic       expValid;
    logic       expErr;
    logic [7:0] expData;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic        v;
    logic        e;
    logic [7:0]  d;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;

  int unsigned cyc;
  int          testsRun;
  int          testsFailed;
  logic        monOn;
  logic [7:0]  curData;
  logic [7:0]  drvLast;
  exp_t        expQ[$];
  vec_t        vecs[6];

  uart_rx dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge number n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: a pulse is allowed only on the predicted cycle, otherwise the
  // outputs must sit idle with rx_data holding the last good byte.
  always @(negedge clk) begin
    if (monOn) begin
      if (expQ.size() != 0 && expQ[0].cyc < cyc) begin
        checkOutput("missedPulse", 32'(expQ[0].cyc), 32'(cyc));
        void'(expQ.pop_front());
      end
      if (expQ.size() != 0 && expQ[0].cyc == cyc) begin
        checkOutput("pulse", {21'd0, rx_busy, rx_valid, rx_err, rx_data},
                    {21'd0, 1'b0, expQ[0].v, expQ[0].e, expQ[0].d});
        curData = expQ[0].d;
        void'(expQ.pop_front());
      end else begin
        checkOutput("idleOutputs", {22'd0, rx_valid, rx_err, rx_data},
                    {22'd0, 1'b0, 1'b0, curData});
      end
    end
  end

  // Drives one full frame starting just after a posedge and queues the
  // predicted outcome; rx is left at the stop-bit level on return.
  task automatic applyStimulus(input logic [7:0] d, input logic stopBit,
                               input logic expValid, input logic expErr,
                               input logic [7:0] expData);
    exp_t e;
    e.cyc = cyc + 1 + PULSE_OFFS;
    e.v   = expValid;
    e.e   = expErr;
    e.d   = expData;
    expQ.push_back(e);
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rx = stopBit;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && expQ.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (expQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc         = 0;
    testsRun    = 0;
    testsFailed = 0;
    monOn       = 1'b0;
    curData     = 8'h00;
    drvLast     = 8'h00;
    rx          = 1'b1;
    rstn        = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 20, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h01, 1'b1, 15, 1'b1, 1'b0, 8'h01};
    vecs[4] = '{8'h5A, 1'b1, 10, 1'b1, 1'b0, 8'h5A};
    vecs[5] = '{8'h3C, 1'b0, 0,  1'b0, 1'b1, 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetData",  32'(rx_data), 32'h00);
    checkOutput("resetValid", 32'(rx_valid), 32'd0);
    checkOutput("resetErr",   32'(rx_err), 32'd0);
    checkOutput("resetBusy",  32'(rx_busy), 32'd0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    monOn = 1'b1;

    // Table: loopback, back-to-back frames, then a framing error.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].expValid,
                    vecs[i].expErr, vecs[i].expData);
      if (vecs[i].expValid) drvLast = vecs[i].expData;
      repeat (vecs[i].gap) @(posedge clk);
      #1;
    end
    drain();

    // Line held low after the framing error: nothing may start.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checkOutput("holdLowBusy", 32'(rx_busy), 32'd0);
    end
    @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("releaseBusy", 32'(rx_busy), 32'd0);
    end

    // Glitch: 10 clocks low, busy only between k+2 and k+30.
    begin
      int unsigned k;
      int unsigned d;
      @(negedge clk);
      rx = 1'b0;
      k  = cyc + 1;
      for (int i = 0; i < 45; i++) begin
        @(negedge clk);
        d = cyc - k;
        checkOutput("glitchBusy", 32'(rx_busy), 32'((d >= 2 && d <= 30) ? 1 : 0));
        if (d == 9) rx = 1'b1;
      end
    end
    repeat (10) @(posedge clk);
    #1;

    // Reset during data bit 4 of 8'hC3.
    begin
      logic [7:0] c3;
      c3 = 8'hC3;
      rx = 1'b0;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
      for (int b = 0; b < 5; b++) begin
        rx = c3[b];
        repeat ((b == 4) ? 20 : BIT_CLKS) @(posedge clk);
        #1;
      end
      checkOutput("midFrameBusy", 32'(rx_busy), 32'd1);
      monOn = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("rstData",  32'(rx_data), 32'h00);
      checkOutput("rstValid", 32'(rx_valid), 32'd0);
      checkOutput("rstErr",   32'(rx_err), 32'd0);
      checkOutput("rstBusy",  32'(rx_busy), 32'd0);
      curData = 8'h00;
      drvLast = 8'h00;
      rx      = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      monOn = 1'b1;
      applyStimulus(8'h81, 1'b1, 1'b1, 1'b0, 8'h81);
      drvLast = 8'h81;
      drain();
    end

    // Random frames against the model: good frames update the byte, a low
    // stop bit flags an error and keeps the previous byte.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       sb;
      int         gap;
      d   = 8'($urandom);
      sb  = ($urandom_range(3) != 0);
      gap = $urandom_range(12);
      applyStimulus(d, sb, sb, !sb, sb ? d : drvLast);
      if (sb) drvLast = d;
      if (!sb) begin
        rx = 1'b1;
        if (gap < 3) gap = 3;
      end
      repeat (gap) @(posedge clk);
      #1;
    end
    drain();
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that pairs with `uart_tx` on the debug/control link of the SDRAM controller test harness. It synchronises the asynchronous `rx` line and detects the start bit. It samples each bit at its midpoint and checks the stop bit. It then presents each byte as an 8-bit word with a one-cycle valid pulse, or flags a framing error. Frame format matches `uart_tx`: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.

## Interface
- `BAUD_END`, 56: bit period is `BAUD_END+1` clocks (56 for simulation, equal to `uart_tx`; set from FPGA_FREQ/BAUD_RATE for synthesis).
- `BAUD_MID`, `BAUD_END/2` (28): counter value at which a bit is sampled.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous to `clk`, idles high.
- `rx_data`  out  8  last correctly framed byte; reset 8'h00.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates; reset 0.
- `rx_err`  out  1  one-cycle pulse on framing error (stop bit sampled 0); reset 0.
- `rx_busy`  out  1  high while a frame is in progress (state != IDLE); reset 0.

## Operation
- Synchroniser: two flops `rx_s1`→`rx_s2`, plus a history flop `rx_d`. All three reset to 1.
- A falling edge (`fall`) is `rx_d==1 && rx_s2==0`.
- A line held low never produces `fall`; it must go high first.
- FSM states are IDLE, START, DATA and STOP. `baud_cnt` counts 0..`BAUD_END`, then wraps to 0. `bit_idx` counts 0..7.
- IDLE:
  - On `fall`, go to START with `baud_cnt` cleared to 0.
  - Otherwise `baud_cnt` holds at 0.
- START:
  - At `baud_cnt==BAUD_MID`, sample `rx_s2`.
  - If the sample is 1, treat it as a glitch: return to IDLE with no pulse.
  - At `baud_cnt==BAUD_END`, go to DATA with `bit_idx`=0.
- DATA:
  - At `baud_cnt==BAUD_MID`, shift right: `shreg <= {rx_s2, shreg[7:1]}` (LSB first).
  - At `baud_cnt==BAUD_END`: if `bit_idx==7` go to STOP, else increment `bit_idx`.
- STOP: sample at `baud_cnt==BAUD_MID`, then return to IDLE immediately. Leaving at mid-stop gives the next start edge a half-bit of margin.
  - Sample 1: `rx_data <= shreg` and `rx_valid` pulses.
  - Sample 0: `rx_err` pulses and `rx_data` keeps its previous value.
- `rx_valid` and `rx_err` are mutually exclusive and never high for more than one cycle.
- Reset mid-frame: everything returns to reset values at once; the partial byte is discarded with no pulse.
- There is no backpressure. The consumer must take `rx_data` on `rx_valid`. `rx_data` stays stable until the next valid frame.

## Timing
- Let edge k be the first `clk` edge at which `rx_s1` captures 0.
  - `rx_s2` is 0 at edge k+1.
  - The FSM enters START at edge k+2.
- The start-bit sample is registered at edge k+2+`BAUD_MID`+1, i.e. k+31.
- Bit n (n = 0..7) is sampled at edge k+2+(n+1)(`BAUD_END`+1)+`BAUD_MID`+1.
- `rx_valid`/`rx_err` go high at edge k+2+9(`BAUD_END`+1)+`BAUD_MID`+1. With default parameters that is k+544. They go low at the next edge.
- `rx_busy` goes high at edge k+2 and low at the same edge as the valid/err pulse.
  - On glitch rejection, `rx_busy` goes low at edge k+31.
- Minimum frame spacing accepted is `uart_tx` back-to-back output: a stop bit of `BAUD_END`+1 clocks followed directly by the next start bit.

## Structure
- Shared package `uart_pkg` holds:
  - `BAUD_END`, `BAUD_MID`, `BIT_END` (=9), so `uart_tx` and `uart_rx` agree.
  - The rx state enum (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
- One sub-module, `uart_sync_edge`: the two-flop synchroniser plus falling-edge detect. Its outputs are `rx_s2` and `fall`, with reset value 1 for all flops.
- The rest is a single FSM `always` block plus datapath registers in `uart_rx`.

## Test plan
- Loopback from `uart_tx`:
  - Send `tx_data`=8'hA5 → `rx_data`=8'hA5.
  - Exactly one `rx_valid` pulse, at edge k+544; `rx_err` stays 0.
- Back-to-back frames: drive 8'h00, 8'hFF, 8'h01 with no idle gap → three `rx_valid` pulses, `rx_data` sequence 00, FF, 01, no `rx_err`.
- Glitch: drive `rx` low for 10 clocks, then high → no pulses; `rx_busy` high from k+2 to k+31, then 0.
- Framing error:
  - First receive 8'h5A, then send 8'h3C with the stop bit forced to 0 → one `rx_err` pulse; `rx_valid` stays 0; `rx_data` remains 8'h5A.
  - Hold `rx` low afterwards → no further activity until `rx` returns high.
- Reset mid-frame:
  - Assert `rstn`=0 during data bit 4 of 8'hC3 → all outputs are 0 immediately; `rx_data`=8'h00.
  - After release, a full 8'h81 frame → `rx_data`=8'h81 with a single `rx_valid`.
